// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus adapter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

    // Adapter sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        GAP    = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Request size encodings
    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_REG  = 1'b1;

    // Default geometry: register width, bus word width and beats per register
    localparam int LSU_REG_W = 32;
    localparam int LSU_BUS_W = 16;
    localparam int BEATS     = LSU_REG_W / LSU_BUS_W;

endpackage

// File: rtl/bus_watchdog.sv
// Per-beat ack watchdog: counts cycles a beat spends waiting for ack.
// Latency: expired is combinational from the registered count and run.
// Backpressure: none; the caller holds run while the bus stalls.
module bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of earlier waiting cycles, so the TIMEOUT-th cycle sees TIMEOUT-1
    assign expired = run && (cnt == CW'(TIMEOUT - 1));

    // Count waiting cycles; clear whenever the beat is not active
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lsu_bus_adapter.sv
// Splits register-width loads/stores into lo-first bus-word beats with ack watchdog.
// Latency: 3 cycles single word, 2N+1 cycles full register, with immediate ack.
// Backpressure: req_ready only in IDLE; each beat holds stb until ack or timeout.
module lsu_bus_adapter
    import lsu_pkg::*;
#(
    parameter int REG_W   = LSU_REG_W,
    parameter int BUS_W   = LSU_BUS_W,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_size,
    input  logic              req_sext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [REG_W-1:0]  req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [REG_W-1:0]  resp_rdata,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [BUS_W-1:0]  data_data_o,
    input  logic [BUS_W-1:0]  data_data_i,
    output logic              data_stb_o,
    output logic              data_we_o,
    input  logic              data_ack_i
);

    localparam int N  = REG_W / BUS_W;
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    state_t            state;
    logic              we_q;
    logic              size_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [REG_W-1:0]  wdata_q;
    logic [BW-1:0]     beat_q;
    logic [BUS_W-1:0]  rd_q [N];

    logic              wd_clr;
    logic              wd_run;
    logic              wd_expired;
    logic              last_beat;
    logic [REG_W-1:0]  load_result;

    assign req_ready = (state == IDLE) && !sys_rst;
    assign wd_run    = (state == ACCESS);
    assign wd_clr    = (state != ACCESS);
    assign last_beat = (size_q == SIZE_WORD) ? (beat_q == '0) : (beat_q == BW'(N - 1));

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .clr     (wd_clr),
        .run     (wd_run),
        .expired (wd_expired)
    );

    // Final load value: the word arriving this cycle merged with earlier captured beats
    always_comb begin
        load_result = '0;
        if (!we_q) begin
            if (size_q == SIZE_REG) begin
                for (int i = 0; i < N; i++) begin
                    load_result[i*BUS_W +: BUS_W] = (BW'(i) == beat_q) ? data_data_i : rd_q[i];
                end
            end else if (sext_q) begin
                load_result = {{(REG_W-BUS_W){data_data_i[BUS_W-1]}}, data_data_i};
            end else begin
                load_result = {{(REG_W-BUS_W){1'b0}}, data_data_i};
            end
        end
    end

    // Transaction FSM; all bus and response outputs are registered here
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 1'b0;
            sext_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            beat_q      <= '0;
            data_stb_o  <= 1'b0;
            data_we_o   <= 1'b0;
            data_addr_o <= '0;
            data_data_o <= '0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
            for (int i = 0; i < N; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    if (req_valid) begin
                        we_q        <= req_we;
                        size_q      <= req_size;
                        sext_q      <= req_sext;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        beat_q      <= '0;
                        data_stb_o  <= 1'b1;
                        data_we_o   <= req_we;
                        data_addr_o <= req_addr;
                        data_data_o <= req_wdata[BUS_W-1:0];
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    // An ack coinciding with watchdog expiry takes priority
                    if (data_ack_i) begin
                        if (!we_q) begin
                            rd_q[beat_q] <= data_data_i;
                        end
                        data_stb_o <= 1'b0;
                        data_we_o  <= 1'b0;
                        if (last_beat) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= load_result;
                            state      <= RESP;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                            state  <= GAP;
                        end
                    end else if (wd_expired) begin
                        data_stb_o <= 1'b0;
                        data_we_o  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state      <= RESP;
                    end
                end
                GAP: begin
                    // Re-raise stb so every beat gets its own rising edge
                    data_stb_o  <= 1'b1;
                    data_we_o   <= we_q;
                    data_addr_o <= addr_q + ADDR_W'(beat_q);
                    data_data_o <= wdata_q[int'(beat_q)*BUS_W +: BUS_W];
                    state       <= ACCESS;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed bench for lsu_bus_adapter with a hand-driven bus responder.
// Latency: checks cycle-exact beat, gap and response timing.
// Backpressure: bus ack is delayed, withheld, and spuriously raised.
module tb_lsu_bus_adapter;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_size;
    logic        req_sext;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [15:0] data_addr_o;
    logic [15:0] data_data_o;
    logic [15:0] data_data_i;
    logic        data_stb_o;
    logic        data_we_o;
    logic        data_ack_i;

    int n_cmp = 0;
    int n_err = 0;

    lsu_bus_adapter #(
        .REG_W   (32),
        .BUS_W   (16),
        .ADDR_W  (16),
        .TIMEOUT (8)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_sext    (req_sext),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .resp_rdata  (resp_rdata),
        .data_addr_o (data_addr_o),
        .data_data_o (data_data_o),
        .data_data_i (data_data_i),
        .data_stb_o  (data_stb_o),
        .data_we_o   (data_we_o),
        .data_ack_i  (data_ack_i)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Present a request for one cycle; afterwards the DUT is in its first ACCESS cycle
    task automatic issue(input string tag, input logic we, input logic size, input logic sext,
                         input logic [15:0] addr, input logic [31:0] wdata);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_we    = we;
        req_size  = size;
        req_sext  = sext;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Hold ack low for dly cycles while stb must stay up, then ack with rd
    task automatic run_beat(input string tag, input logic [15:0] a, input logic [15:0] wd,
                            input logic we, input int dly, input logic [15:0] rd);
        for (int i = 0; i < dly; i++) begin
            chk({tag, "_stb_wait"}, {31'd0, data_stb_o}, 32'd1);
            tick();
        end
        data_data_i = rd;
        data_ack_i  = 1'b1;
        chk({tag, "_stb"},  {31'd0, data_stb_o}, 32'd1);
        chk({tag, "_addr"}, {16'd0, data_addr_o}, {16'd0, a});
        chk({tag, "_wdat"}, {16'd0, data_data_o}, {16'd0, wd});
        chk({tag, "_we"},   {31'd0, data_we_o}, {31'd0, we});
        tick();
        data_ack_i  = 1'b0;
        data_data_i = '0;
    endtask

    task automatic expect_resp(input string tag, input logic err, input logic [31:0] rdata);
        chk({tag, "_rvld"},  {31'd0, resp_valid}, 32'd1);
        chk({tag, "_rerr"},  {31'd0, resp_err}, {31'd0, err});
        chk({tag, "_rdata"}, resp_rdata, rdata);
        chk({tag, "_rstb"},  {31'd0, data_stb_o}, 32'd0);
        tick();
        chk({tag, "_rdone"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_ridle"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        sys_rst     = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_size    = 1'b0;
        req_sext    = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        data_data_i = '0;
        data_ack_i  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_stb",   {31'd0, data_stb_o}, 32'd0);
        chk("rst_we",    {31'd0, data_we_o}, 32'd0);
        chk("rst_addr",  {16'd0, data_addr_o}, 32'd0);
        chk("rst_wdat",  {16'd0, data_data_o}, 32'd0);
        chk("rst_rvld",  {31'd0, resp_valid}, 32'd0);
        chk("rst_rerr",  {31'd0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        sys_rst = 1'b0;
        tick();

        // 1: full-register store, immediate ack, 5 cycles
        issue("t1", 1'b1, 1'b1, 1'b0, 16'h0010, 32'hDEADBEEF);
        run_beat("t1b0", 16'h0010, 16'hBEEF, 1'b1, 0, 16'h0000);
        chk("t1_gap_stb",  {31'd0, data_stb_o}, 32'd0);
        chk("t1_gap_rvld", {31'd0, resp_valid}, 32'd0);
        tick();
        run_beat("t1b1", 16'h0011, 16'hDEAD, 1'b1, 0, 16'h0000);
        expect_resp("t1", 1'b0, 32'h0000_0000);

        // 2: full-register load, ack delayed 3 cycles per beat
        issue("t2", 1'b0, 1'b1, 1'b0, 16'h0100, 32'h0000_0000);
        run_beat("t2b0", 16'h0100, 16'h0000, 1'b0, 3, 16'h1234);
        chk("t2_gap_stb", {31'd0, data_stb_o}, 32'd0);
        tick();
        run_beat("t2b1", 16'h0101, 16'h0000, 1'b0, 3, 16'hABCD);
        expect_resp("t2", 1'b0, 32'hABCD1234);

        // 3: single-word load, sign- then zero-extended
        issue("t3s", 1'b0, 1'b0, 1'b1, 16'h0040, 32'h0000_0000);
        run_beat("t3s", 16'h0040, 16'h0000, 1'b0, 1, 16'h8001);
        expect_resp("t3s", 1'b0, 32'hFFFF8001);
        issue("t3z", 1'b0, 1'b0, 1'b0, 16'h0041, 32'h0000_0000);
        run_beat("t3z", 16'h0041, 16'h0000, 1'b0, 0, 16'h8001);
        expect_resp("t3z", 1'b0, 32'h00008001);

        // 4: watchdog expiry after 8 cycles, then ack exactly on cycle 8
        issue("t4", 1'b0, 1'b0, 1'b0, 16'h0050, 32'h0000_0000);
        for (int i = 0; i < 8; i++) begin
            chk("t4_stb_hold", {31'd0, data_stb_o}, 32'd1);
            chk("t4_no_resp",  {31'd0, resp_valid}, 32'd0);
            tick();
        end
        chk("t4_ready_busy", {31'd0, req_ready}, 32'd0);
        expect_resp("t4", 1'b1, 32'h0000_0000);
        issue("t4a", 1'b0, 1'b0, 1'b0, 16'h0051, 32'h0000_0000);
        run_beat("t4a", 16'h0051, 16'h0000, 1'b0, 7, 16'h5A5A);
        expect_resp("t4a", 1'b0, 32'h00005A5A);

        // 5: address wrap on second beat; spurious acks in GAP and IDLE
        issue("t5", 1'b1, 1'b1, 1'b0, 16'hFFFF, 32'hCAFEF00D);
        run_beat("t5b0", 16'hFFFF, 16'hF00D, 1'b1, 0, 16'h0000);
        data_ack_i = 1'b1;
        chk("t5_gap_stb", {31'd0, data_stb_o}, 32'd0);
        tick();
        data_ack_i = 1'b0;
        run_beat("t5b1", 16'h0000, 16'hCAFE, 1'b1, 1, 16'h0000);
        expect_resp("t5", 1'b0, 32'h0000_0000);
        data_ack_i = 1'b1;
        tick();
        chk("t5_idle_stb",  {31'd0, data_stb_o}, 32'd0);
        chk("t5_idle_rvld", {31'd0, resp_valid}, 32'd0);
        tick();
        chk("t5_idle_rdy",  {31'd0, req_ready}, 32'd1);
        data_ack_i = 1'b0;

        // 6: reset during the second beat aborts silently
        issue("t6", 1'b0, 1'b1, 1'b0, 16'h0200, 32'h0000_0000);
        run_beat("t6b0", 16'h0200, 16'h0000, 1'b0, 0, 16'h1111);
        tick();
        chk("t6_b1_stb", {31'd0, data_stb_o}, 32'd1);
        sys_rst = 1'b1;
        tick();
        chk("t6_rst_stb",  {31'd0, data_stb_o}, 32'd0);
        chk("t6_rst_rvld", {31'd0, resp_valid}, 32'd0);
        chk("t6_rst_rdy",  {31'd0, req_ready}, 32'd0);
        sys_rst = 1'b0;
        tick();
        chk("t6_post_rdy",  {31'd0, req_ready}, 32'd1);
        chk("t6_post_rvld", {31'd0, resp_valid}, 32'd0);
        tick();
        chk("t6_post_rvld2", {31'd0, resp_valid}, 32'd0);
        issue("t6n", 1'b1, 1'b0, 1'b0, 16'h0300, 32'h0000_4321);
        run_beat("t6n", 16'h0300, 16'h4321, 1'b1, 2, 16'h0000);
        expect_resp("t6n", 1'b0, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
